// File: rtl/serializer_pkg.sv
// Shared defaults, channel index width and FSM state type for the serializer.
package serializer_pkg;

  localparam int unsigned NUM_CHANNELS_DEF = 7;
  localparam int unsigned WORD_BITS_DEF    = 8;
  // Width of the wr_chan index; 3 bits also lets the top flag out-of-range channels.
  localparam int unsigned CHAN_W           = 3;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

endpackage

// File: rtl/serializer_lane.sv
// One serial lane: staging register, staged flag and MSB-first shift register.
module serializer_lane
  import serializer_pkg::*;
#(
  parameter int unsigned WORD_BITS = WORD_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [WORD_BITS-1:0] wr_data,
  input  logic                 load,
  input  logic                 shift,
  output logic                 staged,
  output logic                 ser_bit
);

  logic [WORD_BITS-1:0] staging_q;
  logic                 staged_q;
  logic [WORD_BITS-1:0] shift_q;

  // Staging side: capture a word and hold it until the shared commit takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_q <= '0;
      staged_q  <= 1'b0;
    end else if (load) begin
      staged_q <= 1'b0;
    end else if (wr_en) begin
      staging_q <= wr_data;
      staged_q  <= 1'b1;
    end
  end

  // Shift side: load on commit, otherwise move one bit towards the MSB per bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if (load) begin
      shift_q <= staging_q;
    end else if (shift) begin
      shift_q <= {shift_q[WORD_BITS-2:0], 1'b0};
    end
  end

  assign staged  = staged_q;
  assign ser_bit = shift_q[WORD_BITS-1];

endmodule

// File: rtl/multi_channel_serializer.sv
// Double-buffered multi-lane serializer: stage one word per channel, then shift all
// lanes out MSB-first in lockstep, back-to-back when the next frame is already staged.
module multi_channel_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int unsigned WORD_BITS    = WORD_BITS_DEF,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter logic        IDLE_LEVEL   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WORD_BITS-1:0]    wr_data,
  input  logic [CHAN_W-1:0]       wr_chan,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [NUM_CHANNELS-1:0] ser_out,
  output logic                    frame_sync,
  output logic                    busy,
  output logic                    err_chan
);

  localparam int unsigned CLK_CNT_W = $clog2(CLKS_PER_BIT >= 2 ? CLKS_PER_BIT : 2);
  localparam int unsigned BIT_CNT_W = $clog2(WORD_BITS);
  localparam logic [CLK_CNT_W-1:0] ClkLast = CLK_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] BitLast = BIT_CNT_W'(WORD_BITS - 1);
  localparam logic [CHAN_W:0]      NumChL  = (CHAN_W + 1)'(NUM_CHANNELS);

  state_e                  state_q, state_d;
  logic [CLK_CNT_W-1:0]    clk_cnt_q, clk_cnt_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [NUM_CHANNELS-1:0] staged;
  logic [NUM_CHANNELS-1:0] lane_bit;
  logic [2**CHAN_W-1:0]    staged_ext;
  logic                    chan_ok;
  logic                    wr_fire;
  logic                    last_cycle;
  logic                    last_bit;
  logic                    commit;
  logic                    shift_en;
  logic [NUM_CHANNELS-1:0] ser_out_q;
  logic                    frame_sync_q;
  logic                    busy_q;
  logic                    err_q;

  // Write port: out-of-range channels are always "ready" so they drain and get flagged.
  always_comb begin
    chan_ok                        = ({1'b0, wr_chan} < NumChL);
    staged_ext                     = '0;
    staged_ext[NUM_CHANNELS-1:0]   = staged;
    wr_ready                       = chan_ok ? ~staged_ext[wr_chan] : 1'b1;
    wr_fire                        = wr_valid & wr_ready & chan_ok;
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
    serializer_lane #(
      .WORD_BITS(WORD_BITS)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_fire && (wr_chan == CHAN_W'(c))),
      .wr_data(wr_data),
      .load   (commit),
      .shift  (shift_en),
      .staged (staged[c]),
      .ser_bit(lane_bit[c])
    );
  end

  // Next-state: commit from idle or on the final cycle of the final bit, else bit timing.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_en   = 1'b0;
    last_cycle = (clk_cnt_q == ClkLast);
    last_bit   = (bit_cnt_q == BitLast);
    commit     = (&staged) &&
                 ((state_q == StIdle) || ((state_q == StShift) && last_cycle && last_bit));
    unique case (state_q)
      StIdle: begin
        if (commit) begin
          state_d   = StShift;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      StShift: begin
        if (commit) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end else if (last_cycle) begin
          clk_cnt_d = '0;
          if (last_bit) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_en  = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Registered outputs trail the shift registers by one cycle; err_chan is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_out_q    <= {NUM_CHANNELS{IDLE_LEVEL}};
      frame_sync_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ser_out_q    <= (state_q == StShift) ? lane_bit : {NUM_CHANNELS{IDLE_LEVEL}};
      frame_sync_q <= (state_q == StShift) && (bit_cnt_q == '0) && (clk_cnt_q == '0);
      busy_q       <= (state_q == StShift);
      err_q        <= err_q | (wr_valid & ~chan_ok);
    end
  end

  assign ser_out    = ser_out_q;
  assign frame_sync = frame_sync_q;
  assign busy       = busy_q;
  assign err_chan   = err_q;

endmodule

// File: tb/tb_multi_channel_serializer.sv
// Scoreboard bench: two DUT instances (1 and 3 clocks per bit) share the write bus.
module tb_multi_channel_serializer;

  localparam int NCH = 7;

  typedef struct packed {
    logic [NCH-1:0] ser;
    logic           fs;
    logic           busy;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     wr_data = '0;
  logic [2:0]     wr_chan = '0;
  logic           wr_valid1 = 1'b0;
  logic           wr_valid3 = 1'b0;
  logic           wr_ready1, wr_ready3;
  logic [NCH-1:0] ser1, ser3;
  logic           fs1, fs3, busy1, busy3, err1, err3;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multi_channel_serializer #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_chan(wr_chan), .wr_valid(wr_valid1),
    .wr_ready(wr_ready1), .ser_out(ser1), .frame_sync(fs1), .busy(busy1), .err_chan(err1)
  );

  multi_channel_serializer #(.CLKS_PER_BIT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_chan(wr_chan), .wr_valid(wr_valid3),
    .wr_ready(wr_ready3), .ser_out(ser3), .frame_sync(fs3), .busy(busy3), .err_chan(err3)
  );

  task automatic push_idle(input int n);
    exp_t e;
    e = '0;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  // Receiver view: bit b of a frame carries word[7-b] on every lane.
  task automatic push_frame(input logic [7:0] w [NCH], input int clks);
    exp_t e;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < clks; k++) begin
        for (int c = 0; c < NCH; c++) e.ser[c] = w[c][7-b];
        e.fs   = (b == 0 && k == 0);
        e.busy = 1'b1;
        q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({ser1, fs1, busy1, err1, wr_ready1} !== {7'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset1 got ser=%b fs=%b busy=%b err=%b rdy=%b want 0000000/0/0/0/1",
               ser1, fs1, busy1, err1, wr_ready1);
    end
    checks++;
    if ({ser3, fs3, busy3, err3, wr_ready3} !== {7'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset3 got ser=%b fs=%b busy=%b err=%b rdy=%b want 0000000/0/0/0/1",
               ser3, fs3, busy3, err3, wr_ready3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0] w [NCH];
    exp_t e, got;
    int it;
    for (int c = 0; c < NCH; c++) w[c] = 8'hA5;
    q.delete();
    push_idle(9);
    push_frame(w, 1);
    push_idle(2);
    it = 0;
    while (q.size() > 0) begin
      wr_valid1 = (it < NCH);
      wr_chan   = it[2:0];
      wr_data   = w[it % NCH];
      @(negedge clk);
      e   = q.pop_front();
      got = {ser1, fs1, busy1};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL basic it=%0d got ser/fs/busy %b/%b/%b want %b/%b/%b",
                 it, got.ser, got.fs, got.busy, e.ser, e.fs, e.busy);
      end
      @(posedge clk);
      #1;
      it++;
    end
    wr_valid1 = 1'b0;
  endtask

  task automatic test_slow();
    logic [7:0] w [NCH];
    exp_t e, got;
    int it;
    for (int c = 0; c < NCH; c++) w[c] = 8'(1 << c);
    q.delete();
    push_idle(9);
    push_frame(w, 3);
    push_idle(2);
    it = 0;
    while (q.size() > 0) begin
      wr_valid3 = (it < NCH);
      wr_chan   = it[2:0];
      wr_data   = w[it % NCH];
      @(negedge clk);
      e   = q.pop_front();
      got = {ser3, fs3, busy3};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL slow it=%0d got ser/fs/busy %b/%b/%b want %b/%b/%b",
                 it, got.ser, got.fs, got.busy, e.ser, e.fs, e.busy);
      end
      @(posedge clk);
      #1;
      it++;
    end
    wr_valid3 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1 [NCH];
    logic [7:0] w2 [NCH];
    exp_t e, got;
    int it;
    for (int c = 0; c < NCH; c++) begin
      w1[c] = 8'h00;
      w2[c] = 8'hFF;
    end
    q.delete();
    push_idle(9);
    push_frame(w1, 1);
    push_frame(w2, 1);
    push_idle(2);
    it = 0;
    while (q.size() > 0) begin
      wr_valid1 = (it < 7) || (it >= 8 && it < 15);
      wr_chan   = (it < 8) ? it[2:0] : 3'(it - 8);
      wr_data   = (it < 8) ? 8'h00 : 8'hFF;
      @(negedge clk);
      e   = q.pop_front();
      got = {ser1, fs1, busy1};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL b2b it=%0d got ser/fs/busy %b/%b/%b want %b/%b/%b",
                 it, got.ser, got.fs, got.busy, e.ser, e.fs, e.busy);
      end
      @(posedge clk);
      #1;
      it++;
    end
    wr_valid1 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] w1 [NCH];
    logic [7:0] w2 [NCH];
    logic [2:0] order [6];
    exp_t e, got;
    int it;
    for (int c = 0; c < NCH; c++) begin
      w1[c] = 8'(c * 17);
      w2[c] = 8'h80 | 8'(c);
    end
    w2[3] = 8'h5A;
    order = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    q.delete();
    push_idle(9);
    push_frame(w1, 1);
    push_idle(1);
    push_frame(w2, 1);
    push_idle(2);
    it = 0;
    while (q.size() > 0) begin
      wr_valid1 = 1'b0;
      wr_chan   = 3'd3;
      wr_data   = 8'h00;
      if (it < 7) begin
        wr_valid1 = 1'b1; wr_chan = it[2:0]; wr_data = w1[it];
      end else if (it == 8) begin
        wr_valid1 = 1'b1; wr_data = 8'h5A;
      end else if (it == 9) begin
        wr_valid1 = 1'b1; wr_data = 8'hC3;
      end else if (it >= 10 && it < 16) begin
        wr_valid1 = 1'b1; wr_chan = order[it-10]; wr_data = w2[order[it-10]];
      end
      @(negedge clk);
      if (it == 9 || it == 16 || it == 17) begin
        checks++;
        if (wr_ready1 !== (it == 17)) begin
          errors++;
          $display("FAIL bp_ready it=%0d got %b want %b", it, wr_ready1, (it == 17));
        end
      end
      e   = q.pop_front();
      got = {ser1, fs1, busy1};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL bp it=%0d got ser/fs/busy %b/%b/%b want %b/%b/%b",
                 it, got.ser, got.fs, got.busy, e.ser, e.fs, e.busy);
      end
      @(posedge clk);
      #1;
      it++;
    end
    wr_valid1 = 1'b0;
  endtask

  task automatic test_invalid();
    wr_valid1 = 1'b1;
    wr_chan   = 3'd7;
    wr_data   = 8'h3C;
    @(negedge clk);
    checks++;
    if ({wr_ready1, err1} !== 2'b10) begin
      errors++;
      $display("FAIL inv_accept got rdy=%b err=%b want 1/0", wr_ready1, err1);
    end
    @(posedge clk);
    #1;
    wr_valid1 = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      wr_chan = 3'(c);
      @(negedge clk);
      checks++;
      if ({wr_ready1, err1, ser1, busy1, fs1} !== {1'b1, 1'b1, 7'h00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL inv ch=%0d got rdy=%b err=%b ser=%b busy=%b fs=%b want 1/1/0000000/0/0",
                 c, wr_ready1, err1, ser1, busy1, fs1);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w [NCH];
    logic [7:0] wf [NCH];
    exp_t e, got;
    int it;
    for (int c = 0; c < NCH; c++) begin
      w[c]  = 8'hFF;
      wf[c] = 8'h0F;
    end
    q.delete();
    push_idle(9);
    push_frame(w, 1);
    for (it = 0; it <= 12; it++) begin
      wr_valid1 = (it < 7) || (it >= 8 && it < 12);
      wr_chan   = (it < 8) ? it[2:0] : 3'(it - 8);
      wr_data   = (it < 8) ? 8'hFF : 8'h00;
      @(negedge clk);
      e   = q.pop_front();
      got = {ser1, fs1, busy1};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rmf it=%0d got ser/fs/busy %b/%b/%b want %b/%b/%b",
                 it, got.ser, got.fs, got.busy, e.ser, e.fs, e.busy);
      end
      if (it < 12) begin
        @(posedge clk);
        #1;
      end
    end
    // Bit 3 is on the wire; reset away from any clock edge.
    wr_valid1 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ser1, busy1, fs1, err1} !== {7'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rmf_async got ser=%b busy=%b fs=%b err=%b want 0000000/0/0/0",
               ser1, busy1, fs1, err1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    push_idle(16);
    it = 0;
    while (q.size() > 0) begin
      wr_valid1 = (it < 6);
      wr_chan   = it[2:0];
      wr_data   = 8'h0F;
      @(negedge clk);
      e   = q.pop_front();
      got = {ser1, fs1, busy1};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rmf_partial it=%0d got ser/fs/busy %b/%b/%b want %b/%b/%b",
                 it, got.ser, got.fs, got.busy, e.ser, e.fs, e.busy);
      end
      @(posedge clk);
      #1;
      it++;
    end
    push_idle(3);
    push_frame(wf, 1);
    push_idle(2);
    it = 0;
    while (q.size() > 0) begin
      wr_valid1 = (it == 0);
      wr_chan   = 3'd6;
      wr_data   = 8'h0F;
      @(negedge clk);
      e   = q.pop_front();
      got = {ser1, fs1, busy1};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rmf_fresh it=%0d got ser/fs/busy %b/%b/%b want %b/%b/%b",
                 it, got.ser, got.fs, got.busy, e.ser, e.fs, e.busy);
      end
      @(posedge clk);
      #1;
      it++;
    end
    wr_valid1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t want finish before 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_slow();
    test_back_to_back();
    test_backpressure();
    test_invalid();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
